zion_basic_circuit_lib_skid_buf: RTL
====================================

Name: zion_basic_circuit_lib_skid_buf

Overview:
- Two-entry valid/ready skid buffer: one pipeline stage with full handshake and a synchronous flush.
- Upstream it sits directly before the team's enable/clear DFF stages. Downstream it feeds them: the output handshake drives their enable, and the flush input aligns with their clear.
- All outputs are registered, which breaks the combinational ready path between stages.

Parameters:
- WIDTH_IN, "_", width of iDat (set from $bits(iDat)).
- WIDTH_OUT, "_", width of oDat (set from $bits(oDat)). Must equal WIDTH_IN.
- INI_DATA, '0, value loaded into both data registers on reset and on flush.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- iClr  input  1  synchronous flush, active high.
- iVld  input  1  upstream data valid.
- oRdy  output  1  ready to upstream.
- iDat  input  WIDTH_IN  upstream data.
- oVld  output  1  data valid to downstream.
- iRdy  input  1  downstream ready.
- oDat  output  WIDTH_OUT  data to downstream.
- oCnt  output  2  number of held entries, 0..2.

Behaviour:
- Handshake:
  - in_fire = iVld & oRdy; out_fire = oVld & iRdy.
  - Once asserted, iVld/iDat must stay stable until in_fire. oVld/oDat are held stable by this block until out_fire.
- Storage:
  - main register drives oDat.
  - skid register holds an entry only in state FULL.
- States, with the values registered after the edge:
  - EMPTY: oVld=0, oRdy=1, oCnt=0.
  - BUSY: oVld=1, oRdy=1, oCnt=1.
  - FULL: oVld=1, oRdy=0, oCnt=2.
- Transitions when rst=0 and iClr=0:
  - EMPTY:
    - in_fire -> BUSY, main<=iDat.
    - else stay. out_fire cannot occur.
  - BUSY:
    - in_fire & out_fire -> BUSY, main<=iDat.
    - in_fire & !out_fire -> FULL, skid<=iDat.
    - !in_fire & out_fire -> EMPTY.
    - neither -> stay.
  - FULL:
    - out_fire -> BUSY, main<=skid.
    - else stay. in_fire is impossible because oRdy=0.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N is on oDat with oVld=1 after edge N.
  - Full throughput of 1 beat/cycle is sustained while iRdy=1.
- Ordering: strict FIFO order; no beat is dropped or duplicated except by flush.
- Timing paths: oRdy, oVld, oDat and oCnt are flop outputs. There is no combinational path from any input to any output.
- Reset (rst=1 at an edge), regardless of other inputs:
  - state->EMPTY; main and skid<=INI_DATA.
  - Registered outputs: oVld=0, oRdy=1, oCnt=0, oDat=INI_DATA.
  - Reset mid-transfer discards all held data.
- Flush (iClr=1 at an edge, rst=0):
  - Same register effect as reset.
  - Priority: rst > iClr > handshake.
  - An in_fire coincident with iClr is discarded; the upstream beat counts as consumed and is not replayed.
  - An out_fire coincident with iClr counts as a completed transfer to downstream.
- Idle hold: when iVld=0 and iRdy=0, all registers hold.
- Data register contents:
  - oDat is don't-care-free: it always equals main, even when oVld=0.
  - main keeps its last value after a drain to EMPTY.
- Parameter check: initial block issues $error if WIDTH_IN != WIDTH_OUT, and calls $finish when CHECK_ERR_EXIT is defined.
- Macro:
  - Provide a ZionBasicCircuitLib instantiation macro with guard/`__DefErr__ handling, the same as for other library cells.
  - Argument order: UnitName, clk, rst, iClr, iVld, oRdy, iDat, oVld, iRdy, oDat, oCnt, INI_DATA='0.

Test Plan:
- Reset with WIDTH=8 and INI_DATA=8'h5A:
  - Stimulus: rst=1 for 2 cycles with iVld=1, iDat=8'hFF.
  - Response: oVld=0, oRdy=1, oCnt=0, oDat=8'h5A.
- Streaming:
  - Stimulus: iRdy=1, iVld=1, iDat=1,2,3,4 on consecutive cycles.
  - Response: oDat=1,2,3,4 with oVld=1 one cycle later each; oCnt stays 1; oRdy never drops.
- Backpressure:
  - Stimulus: iRdy=0, push 8'h11 then 8'h22.
  - Response: oCnt=2, oRdy=0, and oDat holds 8'h11.
  - Then assert iRdy=1: 8'h11 then 8'h22 delivered on successive cycles; oCnt goes 2->1->0 and oRdy returns to 1 after the first pop.
- Flush while FULL:
  - Stimulus: iClr=1 in the same cycle as iVld=1 with iRdy=1.
  - Response: next cycle EMPTY, oVld=0, oDat=INI_DATA. The held entries and the coincident input never appear at oDat.
- Reset beats flush:
  - Stimulus: rst=1 and iClr=1 together, in state BUSY.
  - Response: EMPTY, oDat=INI_DATA. The same result holds with iClr=0.
- Random stress:
  - Stimulus: 10k cycles of random iVld/iRdy/iClr (5% flush).
  - Response: a scoreboard confirms FIFO order with no loss outside flushes, and oCnt equals the model occupancy every cycle.

Source files
------------

// File: rtl/zion_basic_circuit_lib_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush. Every output is a flop, so the
// ready path between neighbouring stages is cut here.

`ifndef ZION_BASIC_CIRCUIT_LIB_SKID_BUF_MACRO_GUARD
`define ZION_BASIC_CIRCUIT_LIB_SKID_BUF_MACRO_GUARD
`define ZionBasicCircuitLib_SkidBuf(UnitName,clk_MT,rst_MT,iClr_MT,iVld_MT,oRdy_MT,iDat_MT,oVld_MT,iRdy_MT,oDat_MT,oCnt_MT,INI_DATA_MT='0) \
   zion_basic_circuit_lib_skid_buf #(                                                   \
      .WIDTH_IN ($bits(iDat_MT)),                                                       \
      .WIDTH_OUT($bits(oDat_MT)),                                                       \
      .INI_DATA (INI_DATA_MT)                                                           \
   ) UnitName (                                                                         \
      .clk (clk_MT),                                                                    \
      .rst (rst_MT),                                                                    \
      .iClr(iClr_MT),                                                                   \
      .iVld(iVld_MT),                                                                   \
      .oRdy(oRdy_MT),                                                                   \
      .iDat(iDat_MT),                                                                   \
      .oVld(oVld_MT),                                                                   \
      .iRdy(iRdy_MT),                                                                   \
      .oDat(oDat_MT),                                                                   \
      .oCnt(oCnt_MT)                                                                    \
   );
`endif

module zion_basic_circuit_lib_skid_buf #(
   parameter int unsigned               WIDTH_IN  = 8,
   parameter int unsigned               WIDTH_OUT = 8,
   parameter logic [WIDTH_IN-1:0]       INI_DATA  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iClr,
   input  logic                 iVld,
   output logic                 oRdy,
   input  logic [WIDTH_IN-1:0]  iDat,
   output logic                 oVld,
   input  logic                 iRdy,
   output logic [WIDTH_OUT-1:0] oDat,
   output logic [1:0]           oCnt
);

   typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

   state_e              state;
   logic [WIDTH_IN-1:0] mainDat;
   logic [WIDTH_IN-1:0] skidDat;
   logic                inFire;
   logic                outFire;

   // Handshake terms only use flopped outputs, so no input reaches an output combinationally.
   assign inFire  = iVld & oRdy;
   assign outFire = oVld & iRdy;
   assign oDat    = mainDat;

   always_ff @(posedge clk) begin
      if (rst || iClr) begin
         state   <= StEmpty;
         mainDat <= INI_DATA;
         skidDat <= INI_DATA;
         oVld    <= 1'b0;
         oRdy    <= 1'b1;
         oCnt    <= 2'd0;
      end else begin
         unique case (state)
            StEmpty: begin
               if (inFire) begin
                  state   <= StBusy;
                  mainDat <= iDat;
                  oVld    <= 1'b1;
                  oRdy    <= 1'b1;
                  oCnt    <= 2'd1;
               end
            end
            StBusy: begin
               if (inFire && outFire) begin
                  mainDat <= iDat;
               end else if (inFire) begin
                  // Downstream stalled: park the new beat behind the one on oDat.
                  state   <= StFull;
                  skidDat <= iDat;
                  oVld    <= 1'b1;
                  oRdy    <= 1'b0;
                  oCnt    <= 2'd2;
               end else if (outFire) begin
                  state   <= StEmpty;
                  oVld    <= 1'b0;
                  oRdy    <= 1'b1;
                  oCnt    <= 2'd0;
               end
            end
            StFull: begin
               if (outFire) begin
                  state   <= StBusy;
                  mainDat <= skidDat;
                  oVld    <= 1'b1;
                  oRdy    <= 1'b1;
                  oCnt    <= 2'd1;
               end
            end
            default: begin
               state   <= StEmpty;
               mainDat <= INI_DATA;
               skidDat <= INI_DATA;
               oVld    <= 1'b0;
               oRdy    <= 1'b1;
               oCnt    <= 2'd0;
            end
         endcase
      end
   end

`ifndef SYNTHESIS
   initial begin
      if (WIDTH_IN != WIDTH_OUT) begin
         $error("zion_basic_circuit_lib_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)",
                WIDTH_IN, WIDTH_OUT);
`ifdef CHECK_ERR_EXIT
         $finish;
`endif
      end
   end
`endif

endmodule
